// File: rtl/snake_dir_input.sv
// Direction input stage for the snake game: per-button sync + debounce, press
// detection, reversal filtering and a 2-deep turn queue drained by game steps.

module snake_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16000,
  parameter int CNT_W           = 15
) (
  input  logic clk_16,
  input  logic reset,
  input  logic btn_n,
  output logic press
);
  logic             sync1, sync2, db, db_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_16 or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      db    <= 1'b1;
      db_d  <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      db_d  <= db;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db  <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Falling edge of the debounced level; releases never produce an event.
  assign press = db_d & ~db;
endmodule

module snake_dir_input #(
  parameter int         DEBOUNCE_CYCLES = 16000,
  parameter int         CNT_W           = 15,
  parameter logic [1:0] RESET_DIR       = 2'd2
) (
  input  logic       clk_16,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_up,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       step,
  input  logic       clear,
  output logic [1:0] move_direction,
  output logic       dir_changed,
  output logic [1:0] queue_count,
  output logic       dropped
);
  localparam int NUM_BTN = 4;

  logic [NUM_BTN-1:0] btn_n, press;
  logic [1:0][1:0]    q;
  logic [1:0]         req_dir, ref_dir;
  logic               req_vld, accept, pop, push, drop_nxt, wr_sel;

  // Bit index doubles as the direction code: 0=left 1=up 2=right 3=down.
  assign btn_n = {btn_down, btn_right, btn_up, btn_left};

  generate
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      snake_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_db (
        .clk_16(clk_16),
        .reset (reset),
        .btn_n (btn_n[i]),
        .press (press[i])
      );
    end
  endgenerate

  always_comb begin
    req_dir = 2'd0;
    for (int i = NUM_BTN - 1; i >= 0; i--)
      if (press[i]) req_dir = 2'(i);
    req_vld = |press;
    // New turns are judged against the last turn that will be taken.
    case (queue_count)
      2'd2:    ref_dir = q[1];
      2'd1:    ref_dir = q[0];
      default: ref_dir = move_direction;
    endcase
    accept   = req_vld && (req_dir != ref_dir) && (req_dir != (ref_dir ^ 2'd2));
    pop      = step && (queue_count != 2'd0);
    push     = accept && ((queue_count != 2'd2) || step);
    drop_nxt = accept && (queue_count == 2'd2) && !step;
    wr_sel   = (queue_count == 2'd2) || ((queue_count == 2'd1) && !pop);
  end

  always_ff @(posedge clk_16 or negedge reset) begin
    if (!reset) begin
      q              <= '0;
      queue_count    <= 2'd0;
      move_direction <= RESET_DIR;
      dir_changed    <= 1'b0;
      dropped        <= 1'b0;
    end else if (clear) begin
      queue_count    <= 2'd0;
      move_direction <= RESET_DIR;
      dir_changed    <= 1'b0;
      dropped        <= 1'b0;
    end else begin
      dir_changed <= pop;
      dropped     <= drop_nxt;
      if (pop) begin
        move_direction <= q[0];
        q[0]           <= q[1];
      end
      // The write slot accounts for a same-cycle pop shifting the queue.
      if (push) q[wr_sel] <= req_dir;
      queue_count <= queue_count - {1'b0, pop} + {1'b0, push};
    end
  end
endmodule

// File: tb/tb_snake_dir_input.sv
// Self-checking bench for snake_dir_input: directed scenarios plus random
// button/step/clear traffic compared against a behavioural model.

module tb_snake_dir_input;
  localparam int DC = 4;

  logic       clk_16 = 1'b0;
  logic       reset = 1'b1;
  logic       btn_left = 1'b1, btn_up = 1'b1, btn_right = 1'b1, btn_down = 1'b1;
  logic       step = 1'b0, clear = 1'b0;
  logic [1:0] move_direction, queue_count;
  logic       dir_changed, dropped;

  int n_chk = 0, n_pass = 0;
  int seen_dc = 0, seen_drop = 0;

  // Reference model state
  int mq[$];
  int m_dir;
  bit m_db[4];
  bit pend[4];
  bit hist[4][$];
  bit exp_dc, exp_drop;

  snake_dir_input #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (3),
    .RESET_DIR      (2'd2)
  ) dut (
    .clk_16        (clk_16),
    .reset         (reset),
    .btn_left      (btn_left),
    .btn_up        (btn_up),
    .btn_right     (btn_right),
    .btn_down      (btn_down),
    .step          (step),
    .clear         (clear),
    .move_direction(move_direction),
    .dir_changed   (dir_changed),
    .queue_count   (queue_count),
    .dropped       (dropped)
  );

  always #5 clk_16 = ~clk_16;

  function automatic void model_reset();
    mq.delete();
    m_dir = 2; exp_dc = 0; exp_drop = 0;
    for (int b = 0; b < 4; b++) begin
      m_db[b] = 1; pend[b] = 0;
      hist[b].delete();
      for (int k = 0; k < DC + 2; k++) hist[b].push_back(1'b1);
    end
  endfunction

  // One clock edge: apply last edge's press (if any) to the turn queue, then
  // decide from the raw sample history whether a debounced level flips now.
  function automatic void model_step(logic [3:0] raw, bit stp, bit clr);
    int d, rf, len;
    bit acc, full, hit;
    bit np[4];
    exp_dc = 0; exp_drop = 0;
    if (clr) begin
      mq.delete();
      m_dir = 2;
    end else begin
      d = -1;
      for (int b = 3; b >= 0; b--) if (pend[b]) d = b;
      rf   = (mq.size() > 0) ? mq[$] : m_dir;
      acc  = (d >= 0) && (d != rf) && (d != (rf + 2) % 4);
      full = (mq.size() == 2);
      if (stp && mq.size() > 0) begin
        m_dir  = mq.pop_front();
        exp_dc = 1;
      end
      if (acc) begin
        if (full && !stp) exp_drop = 1;
        else mq.push_back(d);
      end
    end
    for (int b = 0; b < 4; b++) begin
      hist[b].push_back(raw[b]);
      if (hist[b].size() > DC + 3) void'(hist[b].pop_front());
      len = hist[b].size();
      // Level seen by the debouncer lags the raw pin by two samples.
      hit = 1;
      for (int k = len - 2 - DC; k <= len - 3; k++)
        if (hist[b][k] == m_db[b]) hit = 0;
      if (hit) m_db[b] = !m_db[b];
      np[b] = hit && !m_db[b];
    end
    pend = np;
  endfunction

  task automatic cyc();
    logic [3:0] raw;
    bit s, c;
    @(posedge clk_16);
    raw = {btn_down, btn_right, btn_up, btn_left};
    s = step; c = clear;
    model_step(raw, s, c);
    @(negedge clk_16);
    if (dir_changed === 1'b1) seen_dc++;
    if (dropped === 1'b1) seen_drop++;
  endtask

  task automatic set_btn(int b, logic v);
    case (b)
      0: btn_left = v;
      1: btn_up = v;
      2: btn_right = v;
      default: btn_down = v;
    endcase
  endtask

  task automatic press(int b, int hold, int settle);
    set_btn(b, 1'b0);
    repeat (hold) cyc();
    set_btn(b, 1'b1);
    repeat (settle) cyc();
  endtask

  task automatic do_step();
    step = 1'b1; cyc(); step = 1'b0;
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    #1;
    n_chk++; if (move_direction !== 2'd2) $display("FAIL reset_dir: got %0d want 2", move_direction); else n_pass++;
    n_chk++; if (queue_count !== 2'd0) $display("FAIL reset_qc: got %0d want 0", queue_count); else n_pass++;
    n_chk++; if (dir_changed !== 1'b0 || dropped !== 1'b0) $display("FAIL reset_pulses: got dc=%b drop=%b want 0 0", dir_changed, dropped); else n_pass++;
    model_reset();
    @(negedge clk_16); @(negedge clk_16);
    reset = 1'b1;
    seen_dc = 0;
    repeat (3) begin do_step(); cyc(); end
    n_chk++; if (move_direction !== 2'd2) $display("FAIL idle_dir: got %0d want 2", move_direction); else n_pass++;
    n_chk++; if (queue_count !== 2'd0) $display("FAIL idle_qc: got %0d want 0", queue_count); else n_pass++;
    n_chk++; if (seen_dc != 0) $display("FAIL idle_dc: got %0d pulses want 0", seen_dc); else n_pass++;
  endtask

  task automatic test_single_press();
    btn_up = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      if (k == 6) begin
        n_chk++; if (queue_count !== 2'd0) $display("FAIL press_early: got qc=%0d want 0 at cycle 6", queue_count); else n_pass++;
      end
    end
    n_chk++; if (queue_count !== 2'd1) $display("FAIL press_latency: got qc=%0d want 1 at cycle 7", queue_count); else n_pass++;
    repeat (13) cyc();
    btn_up = 1'b1;
    repeat (8) cyc();
    n_chk++; if (queue_count !== 2'd1) $display("FAIL release_noevt: got qc=%0d want 1", queue_count); else n_pass++;
    seen_dc = 0;
    do_step();
    n_chk++; if (move_direction !== 2'd1) $display("FAIL step_dir: got %0d want 1", move_direction); else n_pass++;
    n_chk++; if (dir_changed !== 1'b1) $display("FAIL step_dc: got %b want 1", dir_changed); else n_pass++;
    cyc();
    n_chk++; if (seen_dc != 1) $display("FAIL step_dc_once: got %0d pulses want 1", seen_dc); else n_pass++;
  endtask

  task automatic test_bounce_reversal();
    seen_drop = 0;
    for (int k = 0; k < 30; k++) begin
      btn_down = ((k / 2) % 2 == 1);
      cyc();
    end
    btn_down = 1'b1;
    repeat (10) cyc();
    n_chk++; if (queue_count !== 2'd0) $display("FAIL bounce_qc: got %0d want 0", queue_count); else n_pass++;
    clear = 1'b1; cyc(); clear = 1'b0;
    n_chk++; if (move_direction !== 2'd2) $display("FAIL clear_dir: got %0d want 2", move_direction); else n_pass++;
    press(0, 8, 10);
    n_chk++; if (queue_count !== 2'd0) $display("FAIL reversal_qc: got %0d want 0", queue_count); else n_pass++;
    n_chk++; if (seen_drop != 0) $display("FAIL reversal_drop: got %0d pulses want 0", seen_drop); else n_pass++;
  endtask

  task automatic test_queue_full();
    seen_drop = 0;
    press(1, 8, 8);
    press(0, 8, 8);
    n_chk++; if (queue_count !== 2'd2) $display("FAIL full_qc: got %0d want 2", queue_count); else n_pass++;
    press(3, 8, 8);
    n_chk++; if (seen_drop != 1) $display("FAIL full_drop: got %0d pulses want 1", seen_drop); else n_pass++;
    n_chk++; if (queue_count !== 2'd2) $display("FAIL full_qc_after: got %0d want 2", queue_count); else n_pass++;
    do_step();
    n_chk++; if (move_direction !== 2'd1) $display("FAIL full_pop1: got %0d want 1", move_direction); else n_pass++;
    cyc(); do_step();
    n_chk++; if (move_direction !== 2'd0) $display("FAIL full_pop2: got %0d want 0", move_direction); else n_pass++;
    n_chk++; if (queue_count !== 2'd0) $display("FAIL full_empty: got %0d want 0", queue_count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    press(1, 8, 8);
    press(2, 8, 8);
    n_chk++; if (queue_count !== 2'd2) $display("FAIL b2b_setup: got qc=%0d want 2", queue_count); else n_pass++;
    btn_down = 1'b0;
    repeat (6) cyc();
    do_step();
    n_chk++; if (queue_count !== 2'd2) $display("FAIL b2b_qc: got %0d want 2", queue_count); else n_pass++;
    n_chk++; if (move_direction !== 2'd1) $display("FAIL b2b_dir: got %0d want 1", move_direction); else n_pass++;
    n_chk++; if (dropped !== 1'b0) $display("FAIL b2b_drop: got %b want 0", dropped); else n_pass++;
    repeat (2) cyc();
    btn_down = 1'b1;
    repeat (8) cyc();
    do_step();
    n_chk++; if (move_direction !== 2'd2) $display("FAIL b2b_pop1: got %0d want 2", move_direction); else n_pass++;
    cyc(); do_step();
    n_chk++; if (move_direction !== 2'd3) $display("FAIL b2b_tail: got %0d want 3", move_direction); else n_pass++;
  endtask

  task automatic test_clear();
    press(0, 8, 8);
    press(1, 8, 8);
    n_chk++; if (queue_count !== 2'd2 || move_direction !== 2'd3) $display("FAIL clr_setup: got qc=%0d dir=%0d want 2 3", queue_count, move_direction); else n_pass++;
    clear = 1'b1; cyc(); clear = 1'b0;
    n_chk++; if (queue_count !== 2'd0) $display("FAIL clr_qc: got %0d want 0", queue_count); else n_pass++;
    n_chk++; if (move_direction !== 2'd2) $display("FAIL clr_dir: got %0d want 2", move_direction); else n_pass++;
    n_chk++; if (dir_changed !== 1'b0 || dropped !== 1'b0) $display("FAIL clr_pulses: got dc=%b drop=%b want 0 0", dir_changed, dropped); else n_pass++;
  endtask

  task automatic test_async_reset();
    press(1, 8, 8);
    do_step();
    n_chk++; if (move_direction !== 2'd1) $display("FAIL ar_setup_dir: got %0d want 1", move_direction); else n_pass++;
    press(0, 8, 8);
    n_chk++; if (queue_count !== 2'd1) $display("FAIL ar_setup_qc: got %0d want 1", queue_count); else n_pass++;
    btn_up = 1'b0;
    repeat (3) cyc();
    #2 reset = 1'b0;
    #1;
    n_chk++; if (move_direction !== 2'd2) $display("FAIL ar_dir: got %0d want 2", move_direction); else n_pass++;
    n_chk++; if (queue_count !== 2'd0) $display("FAIL ar_qc: got %0d want 0", queue_count); else n_pass++;
    n_chk++; if (dir_changed !== 1'b0 || dropped !== 1'b0) $display("FAIL ar_pulses: got dc=%b drop=%b want 0 0", dir_changed, dropped); else n_pass++;
    model_reset();
    @(negedge clk_16);
    reset = 1'b1;
    repeat (10) cyc();
    n_chk++; if (queue_count !== 2'd1) $display("FAIL ar_held_press: got qc=%0d want 1", queue_count); else n_pass++;
    n_chk++; if (int'(queue_count) != mq.size()) $display("FAIL ar_model_qc: got %0d want %0d", queue_count, mq.size()); else n_pass++;
    btn_up = 1'b1;
    repeat (8) cyc();
  endtask

  task automatic test_random();
    int hold[4];
    logic [3:0] rb;
    rb = 4'hF;
    for (int b = 0; b < 4; b++) hold[b] = $urandom_range(1, 10);
    for (int n = 0; n < 800; n++) begin
      for (int b = 0; b < 4; b++) begin
        hold[b]--;
        if (hold[b] == 0) begin
          rb[b] = ~rb[b];
          hold[b] = $urandom_range(1, 10);
        end
      end
      {btn_down, btn_right, btn_up, btn_left} = rb;
      step  = ($urandom_range(0, 5) == 0);
      clear = ($urandom_range(0, 79) == 0);
      cyc();
      n_chk++; if (move_direction !== 2'(m_dir)) $display("FAIL rnd_dir @%0d: got %0d want %0d", n, move_direction, m_dir); else n_pass++;
      n_chk++; if (int'(queue_count) != mq.size()) $display("FAIL rnd_qc @%0d: got %0d want %0d", n, queue_count, mq.size()); else n_pass++;
      n_chk++; if (dir_changed !== exp_dc) $display("FAIL rnd_dc @%0d: got %b want %b", n, dir_changed, exp_dc); else n_pass++;
      n_chk++; if (dropped !== exp_drop) $display("FAIL rnd_drop @%0d: got %b want %b", n, dropped, exp_drop); else n_pass++;
    end
    {btn_down, btn_right, btn_up, btn_left} = 4'hF;
    step = 1'b0; clear = 1'b0;
    repeat (10) cyc();
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce_reversal();
    test_queue_full();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
